// File: rtl/lif_scheduler.sv
// lif_scheduler: time-multiplexed leaky integrate-and-fire controller.
// Holds the membrane state of N_NEURONS neurons and runs them one at a time
// through a single leak/integrate/fire datapath on every accepted tick.
// Spike IDs leave in ascending order over a one-deep valid/ready port.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   tick          start a pass (accepted in IDLE only)
//   thr           firing threshold, captured on an accepted tick
//   cur_idx       neuron whose current is wanted (scan index in SCAN, else 0)
//   cur_in        current for cur_idx, combinational from an external mux
//   spike_valid   spike event pending
//   spike_id      ID of the pending spike
//   spike_ready   consumer accepts the pending spike
//   busy          pass in progress (SCAN or DONE)
//   done          one-cycle pulse when a pass completes
//   overrun       sticky: tick arrived while busy
//   rd_sel        state readback select
//   rd_state      registered state[rd_sel], 0 when out of range
module lif_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int STATE_W    = 8,
    parameter int CUR_W      = 12,
    parameter int LEAK_SHIFT = 1,
    localparam int IW        = $clog2(N_NEURONS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [STATE_W-1:0] thr,
    output logic [IW-1:0]      cur_idx,
    input  logic [CUR_W-1:0]   cur_in,
    output logic               spike_valid,
    output logic [IW-1:0]      spike_id,
    input  logic               spike_ready,
    output logic               busy,
    output logic               done,
    output logic               overrun,
    input  logic [IW-1:0]      rd_sel,
    output logic [STATE_W-1:0] rd_state
);
    // One extra bit over the wider operand so the add never wraps.
    localparam int SUM_W = ((STATE_W > CUR_W) ? STATE_W : CUR_W) + 1;
    localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-STATE_W){1'b0}}, {STATE_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, SCAN, DONE} fsm_t;
    fsm_t fsm, fsm_nxt;

    logic [N_NEURONS-1:0][STATE_W-1:0] mem;
    logic [STATE_W-1:0] thr_q;
    logic [IW-1:0]      idx;

    logic [STATE_W-1:0] s, decayed, sat;
    logic [SUM_W-1:0]   sum;
    logic               stall, commit, fire, last;

    // A held spike blocks the datapath so events are never dropped and
    // stay in ID order.
    assign stall  = spike_valid & ~spike_ready;
    assign commit = (fsm == SCAN) & ~stall;
    assign last   = (idx == IW'(N_NEURONS - 1));

    assign s       = mem[idx];
    assign decayed = s - (s >> LEAK_SHIFT);
    assign sum     = SUM_W'(decayed) + SUM_W'(cur_in);
    assign sat     = (sum > SAT_MAX) ? {STATE_W{1'b1}} : sum[STATE_W-1:0];
    assign fire    = (sat >= thr_q);

    assign busy    = (fsm != IDLE);
    assign cur_idx = (fsm == SCAN) ? idx : '0;

    always_ff @(posedge clk) begin
        if (reset) fsm <= IDLE;
        else       fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        done    = 1'b0;
        case (fsm)
            IDLE: if (tick) fsm_nxt = SCAN;
            SCAN: if (commit && last) fsm_nxt = DONE;
            DONE: if (!stall) begin
                done    = 1'b1;
                fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem         <= '0;
            thr_q       <= '0;
            idx         <= '0;
            spike_valid <= 1'b0;
            spike_id    <= '0;
            overrun     <= 1'b0;
            rd_state    <= '0;
        end else begin
            if (fsm == IDLE && tick) begin
                thr_q <= thr;
                idx   <= '0;
            end
            if (commit) begin
                mem[idx] <= fire ? '0 : sat;
                if (!last) idx <= idx + 1'b1;
            end
            // A new spike on a transfer cycle reloads the slot directly.
            if (commit && fire) begin
                spike_valid <= 1'b1;
                spike_id    <= idx;
            end else if (spike_valid && spike_ready) begin
                spike_valid <= 1'b0;
            end
            if (tick && fsm != IDLE) overrun <= 1'b1;
            rd_state <= (int'(rd_sel) < N_NEURONS) ? mem[rd_sel] : '0;
        end
    end
endmodule
